exe_muldiv: RTL and testbench
=============================

# exe_muldiv

Execute-stage HI/LO unit for the 5-stage pipeline, fed directly by the ID/EXE pipeline register outputs (operands, decoded multiply/divide op).
- Multiply and MTHI/MTLO: single-cycle.
- Signed/unsigned divide: multi-cycle radix-2 restoring iteration, holding the front of the pipeline via a stall request to the stall controller.
- Owns the architectural HI/LO registers.

## Interface
Parameters:
- DIV_ITERS, 32, quotient bits produced (one per BUSY cycle)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_op  in  3  MD_OP_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO (from ID/EXE register)
- i_da  in  32  rs operand (dividend/multiplicand/MTHI-MTLO source)
- i_db  in  32  rt operand (divisor/multiplier)
- i_stall_exe  in  1  stall[3] from stall controller; EXE instruction held this cycle
- i_annul  in  1  synchronous flush of the EXE instruction (exception/branch kill)
- o_stall_req  out  1  request stall of stages 0..3 (to stall controller)
- o_busy  out  1  divider FSM not IDLE
- o_hi  out  32  architectural HI
- o_lo  out  32  architectural LO

## Operation
- FSM states: IDLE, BUSY, DONE. Reset: state IDLE, count 0, HI=LO=0, all internal operand regs 0.
- IDLE, op DIV/DIVU, no annul:
  - Latch |da|, |db| (signed) or raw (unsigned), result-sign flags, count=0.
  - Go BUSY; o_stall_req=1 combinationally in this cycle.
  - divisor==0: go straight to DONE with Q=0xFFFF_FFFF, R=da.
- BUSY:
  - One restoring step per cycle: shift remainder, trial-subtract, set quotient bit.
  - count increments; after count==DIV_ITERS-1 go DONE.
  - o_stall_req=1 throughout.
- DONE:
  - Apply sign correction: Q negated if signs differ (signed); R takes dividend sign.
  - o_stall_req=0.
  - If i_stall_exe=0: LO<=Q, HI<=R, go IDLE.
  - If i_stall_exe=1 (stall from a later stage): remain DONE, no write, no restart.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: Q=0x8000_0000, R=0 (falls out of the magnitude algorithm; must be checked).
- MULT/MULTU/MTHI/MTLO take effect in IDLE only, at the clock edge, when i_stall_exe=0 and i_annul=0:
  - MULT/MULTU: {HI,LO}<=64-bit signed/unsigned product.
  - MTHI: HI<=da. MTLO: LO<=da.
- No write occurs while i_stall_exe=1.
- i_annul=1 in any state: next state IDLE, no HI/LO write, o_stall_req=0 that cycle.
- MD_OP_NONE: no effect.

## Timing
- DIV/DIVU latency: 1 IDLE cycle + DIV_ITERS BUSY cycles with o_stall_req=1 (33 at default).
  - DONE cycle: stall released; HI/LO visible on o_hi/o_lo the cycle after DONE.
- Divide by zero: exactly 1 stall cycle, then DONE.
- MULT/MTHI/MTLO: zero stall; HI/LO updated at the edge ending the EXE cycle.
- Operands are sampled only in IDLE; the ID/EXE register holds them stable while stalled, but the block does not re-read them.
- o_stall_req is combinational from state and i_op; the stall controller registers its effect. o_busy is decoded from state.
- Reset asserted mid-division: immediate IDLE, HI/LO cleared, o_stall_req=0.

## Structure
- Shared definitions in global_define.vh:
  - MD_OP_* 3-bit encodings.
  - FSM state encodings MD_IDLE/MD_BUSY/MD_DONE.
  - Reuse existing Stop/NoStop/ZeroWord.
- Sub-module div_core:
  - Holds the magnitude remainder/quotient registers and one restoring step per enable.
  - Ports: clk, reset, load, step, dividend, divisor, quotient, remainder.
- exe_muldiv contains the FSM, sign handling, multiplier and the HI/LO registers.

## Test plan
- MULT 0xFFFF_FFFE × 3 (−2×3) → HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, no stall; MULTU same operands → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV −7/2: o_stall_req high exactly 33 cycles → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 100/7 → LO=14, HI=2.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0; DIVU 5/0 → 1 stall cycle, LO=0xFFFF_FFFF, HI=5.
- DIV in progress: annul at BUSY cycle 10 → IDLE next cycle, stall drops, HI/LO keep prior values (preload via MTHI 0x1234, MTLO 0x5678).
- DIV reaches DONE while i_stall_exe=1 for 3 cycles → stays DONE, no restart, single HI/LO write on first cycle with i_stall_exe=0.
- Reset asserted mid-BUSY, asynchronously between edges → o_hi=o_lo=0, o_busy=0 immediately.

Source files
------------

// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the execute-stage HI/LO unit.
//   - MD_OP_* operation encodings as presented by the ID/EXE register
//   - MD_IDLE/MD_BUSY/MD_DONE divider FSM state encodings
//   - STOP/NO_STOP stall levels, ZERO_WORD constant
//   - md_result_t packed {hi, lo} result payload
package exe_muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  // Two's-complement negate when neg is set (magnitude / sign restore).
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (ZERO_WORD - x) : x;
  endfunction

endpackage

// File: rtl/exe_muldiv_div_core.sv
// Unsigned radix-2 restoring divider datapath.
//   clk, reset  : clock, async active-high reset
//   load        : capture dividend/divisor magnitudes, clear remainder
//   step        : perform one restoring iteration
//   dividend    : dividend magnitude (quotient register initial value)
//   divisor     : divisor magnitude
//   quotient    : quotient register (holds dividend right after load)
//   remainder   : partial / final remainder
module div_core
  import exe_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // Shift next dividend bit into the remainder and trial-subtract.
  // trial[XLEN] set means the subtraction borrowed (restore).
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      if (!trial[XLEN]) begin
        rem_q <= trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, multi-cycle
// DIV/DIVU with pipeline stall request; owns architectural HI/LO.
//   clk, reset   : clock, async active-high reset
//   i_op         : MD_OP_* from the ID/EXE register
//   i_da, i_db   : rs / rt operands
//   i_stall_exe  : EXE instruction held this cycle by a later stage
//   i_annul      : flush of the EXE instruction
//   o_stall_req  : combinational stall request for stages 0..3
//   o_busy       : divider FSM not idle
//   o_hi, o_lo   : architectural HI / LO
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_da,
  input  logic [XLEN-1:0] i_db,
  input  logic            i_stall_exe,
  input  logic            i_annul,
  output logic            o_stall_req,
  output logic            o_busy,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int unsigned CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, r_neg_q, dz_q;
  logic [XLEN-1:0]  hi_q, lo_q;

  logic             is_div, div_signed, mul_signed;
  logic             load, step;
  logic             wr_div, wr_prod, wr_hi, wr_lo;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN-1:0]  core_quo, core_rem;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  md_result_t       div_res;

  // Operand decode and magnitudes (sampled only when load fires in IDLE).
  always_comb begin
    is_div     = (i_op == MD_OP_DIV) || (i_op == MD_OP_DIVU);
    div_signed = (i_op == MD_OP_DIV);
    mul_signed = (i_op == MD_OP_MULT);
    a_mag      = neg_if(i_da, div_signed & i_da[XLEN-1]);
    b_mag      = neg_if(i_db, div_signed & i_db[XLEN-1]);
  end

  // 64-bit product; sign extension selects signed vs unsigned multiply.
  always_comb begin
    mul_a = {{XLEN{mul_signed & i_da[XLEN-1]}}, i_da};
    mul_b = {{XLEN{mul_signed & i_db[XLEN-1]}}, i_db};
    prod  = mul_a * mul_b;
  end

  div_core u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Sign restore; for a zero divisor the core still holds |dividend| in its
  // quotient register, which becomes the remainder (giving R = dividend).
  always_comb begin
    div_res.lo = dz_q ? '1 : neg_if(core_quo, q_neg_q);
    div_res.hi = neg_if(dz_q ? core_quo : core_rem, r_neg_q);
  end

  // FSM next state, datapath controls and stall request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    step        = 1'b0;
    wr_div      = 1'b0;
    wr_prod     = 1'b0;
    wr_hi       = 1'b0;
    wr_lo       = 1'b0;
    o_stall_req = NO_STOP;

    case (state_q)
      MD_IDLE: begin
        if (!i_annul) begin
          if (is_div) begin
            load        = 1'b1;
            cnt_d       = '0;
            o_stall_req = STOP;
            state_d     = (i_db == ZERO_WORD) ? MD_DONE : MD_BUSY;
          end else if (!i_stall_exe) begin
            case (i_op)
              MD_OP_MULT, MD_OP_MULTU: wr_prod = 1'b1;
              MD_OP_MTHI:              wr_hi   = 1'b1;
              MD_OP_MTLO:              wr_lo   = 1'b1;
              default: ;
            endcase
          end
        end
      end
      MD_BUSY: begin
        if (i_annul) begin
          state_d = MD_IDLE;
        end else begin
          o_stall_req = STOP;
          step        = 1'b1;
          cnt_d       = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_LAST) state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        if (i_annul) begin
          state_d = MD_IDLE;
        end else if (!i_stall_exe) begin
          wr_div  = 1'b1;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase

    // Reset forces IDLE immediately, so the request must drop with it.
    if (reset) o_stall_req = NO_STOP;
  end

  // FSM state, iteration count and latched sign/zero flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        q_neg_q <= div_signed & (i_da[XLEN-1] ^ i_db[XLEN-1]);
        r_neg_q <= div_signed & i_da[XLEN-1];
        dz_q    <= (i_db == ZERO_WORD);
      end
    end
  end

  // Architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_div) begin
      {hi_q, lo_q} <= div_res;
    end else if (wr_prod) begin
      {hi_q, lo_q} <= prod;
    end else begin
      if (wr_hi) hi_q <= i_da;
      if (wr_lo) lo_q <= i_da;
    end
  end

  assign o_busy = (state_q != MD_IDLE);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
module tb_exe_muldiv;
  import exe_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  i_op;
  logic [31:0] i_da, i_db;
  logic        i_stall_exe, i_annul;
  logic        o_stall_req, o_busy;
  logic [31:0] o_hi, o_lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  exe_muldiv #(.DIV_ITERS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_op        (i_op),
    .i_da        (i_da),
    .i_db        (i_db),
    .i_stall_exe (i_stall_exe),
    .i_annul     (i_annul),
    .o_stall_req (o_stall_req),
    .o_busy      (o_busy),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Count cycles with o_stall_req high, sampling mid-cycle.
  task automatic count_stall(output int n);
    n = 0;
    while (o_stall_req && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL stall_timeout: stall still high after %0d cycles", n);
    end
  endtask

  // Present one instruction in EXE and let it retire; returns stall cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    i_op = op;
    i_da = a;
    i_db = b;
    #1;
    count_stall(n);
    @(negedge clk);
    i_op = MD_OP_NONE;
    #1;
  endtask

  // Architectural reference model.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int stall);
    longint      sa, sb, sp;
    logic [63:0] up;
    stall = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_OP_MULT: begin
        sp = sa * sb;
        {hi, lo} = sp;
      end
      MD_OP_MULTU: begin
        up = 64'(a) * 64'(b);
        {hi, lo} = up;
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        if (b == 32'd0) begin
          stall = 1;
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          stall = 33;
          if (op == MD_OP_DIV) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
          end else begin
            lo = a / b;
            hi = a % b;
          end
        end
      end
      MD_OP_MTHI: hi = a;
      MD_OP_MTLO: lo = a;
      default: ;
    endcase
  endtask

  initial begin
    int          n, es;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{MD_OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 0};
    vecs[1]  = '{MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 0};
    vecs[2]  = '{MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{MD_OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[4]  = '{MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[5]  = '{MD_OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{MD_OP_MTHI,  32'h0000_ABCD, 32'd9,         32'h0000_ABCD, 32'hFFFF_FFFF, 0};
    vecs[7]  = '{MD_OP_MTLO,  32'd1,         32'd9,         32'h0000_ABCD, 32'd1,         0};
    vecs[8]  = '{MD_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[9]  = '{MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0};
    vecs[10] = '{MD_OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};

    reset = 1'b1;
    i_op = MD_OP_NONE;
    i_da = '0;
    i_db = '0;
    i_stall_exe = 1'b0;
    i_annul = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_hi", o_hi, 32'd0);
    chk("reset_lo", o_lo, 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_stall", 32'(o_stall_req), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk("tbl_hi", o_hi, vecs[i].hi);
      chk("tbl_lo", o_lo, vecs[i].lo);
      chk("tbl_stall_cycles", 32'(n), 32'(vecs[i].stall));
      chk("tbl_busy_after", 32'(o_busy), 32'd0);
    end
    m_hi = vecs[10].hi;
    m_lo = vecs[10].lo;

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 6));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0)      b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else                                b = 32'($urandom_range(1, 50));
      if ($urandom_range(0, 3) == 0) a = {1'b1, a[30:0]};
      model(op, a, b, m_hi, m_lo, es);
      run_op(op, a, b, n);
      chk("rnd_hi", o_hi, m_hi);
      chk("rnd_lo", o_lo, m_lo);
      chk("rnd_stall_cycles", 32'(n), 32'(es));
    end

    // Annul in BUSY cycle 10: no write, stall drops, back to IDLE.
    run_op(MD_OP_MTHI, 32'h1234, 32'd0, n);
    run_op(MD_OP_MTLO, 32'h5678, 32'd0, n);
    m_hi = 32'h1234;
    m_lo = 32'h5678;
    chk("pre_annul_hi", o_hi, m_hi);
    chk("pre_annul_lo", o_lo, m_lo);
    @(negedge clk);
    i_op = MD_OP_DIV;
    i_da = 32'd1000;
    i_db = 32'd3;
    #1;
    chk("annul_start_stall", 32'(o_stall_req), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("annul_busy10", 32'(o_busy), 32'd1);
    chk("annul_stall10", 32'(o_stall_req), 32'd1);
    i_annul = 1'b1;
    #1;
    chk("annul_stall_drop", 32'(o_stall_req), 32'd0);
    @(negedge clk);
    i_annul = 1'b0;
    i_op = MD_OP_NONE;
    #1;
    chk("annul_idle", 32'(o_busy), 32'd0);
    chk("annul_stall_after", 32'(o_stall_req), 32'd0);
    chk("annul_hi", o_hi, m_hi);
    chk("annul_lo", o_lo, m_lo);
    @(negedge clk);
    #1;
    chk("annul_no_restart", 32'(o_busy), 32'd0);

    // DONE held by i_stall_exe for 3 cycles: no write, no restart.
    @(negedge clk);
    i_op = MD_OP_DIVU;
    i_da = 32'd100;
    i_db = 32'd7;
    #1;
    count_stall(n);
    chk("hold_stall_cycles", 32'(n), 32'd33);
    i_stall_exe = 1'b1;
    chk("hold_done1_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("hold_busy", 32'(o_busy), 32'd1);
      chk("hold_no_stall", 32'(o_stall_req), 32'd0);
      chk("hold_hi", o_hi, m_hi);
      chk("hold_lo", o_lo, m_lo);
    end
    @(negedge clk);
    i_stall_exe = 1'b0;
    #1;
    chk("hold_release_busy", 32'(o_busy), 32'd1);
    chk("hold_release_hi", o_hi, m_hi);
    @(negedge clk);
    i_op = MD_OP_NONE;
    #1;
    m_hi = 32'd2;
    m_lo = 32'd14;
    chk("hold_write_hi", o_hi, m_hi);
    chk("hold_write_lo", o_lo, m_lo);
    chk("hold_write_idle", 32'(o_busy), 32'd0);

    // Asynchronous reset mid-BUSY.
    run_op(MD_OP_MTHI, 32'hDEAD_BEEF, 32'd0, n);
    chk("prerst_hi", o_hi, 32'hDEAD_BEEF);
    @(negedge clk);
    i_op = MD_OP_DIV;
    i_da = 32'd12345;
    i_db = 32'd17;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_hi", o_hi, 32'd0);
    chk("rst_mid_lo", o_lo, 32'd0);
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_stall", 32'(o_stall_req), 32'd0);
    @(negedge clk);
    i_op = MD_OP_NONE;
    reset = 1'b0;
    #1;
    chk("rst_release_busy", 32'(o_busy), 32'd0);
    run_op(MD_OP_DIVU, 32'd50, 32'd5, n);
    chk("post_rst_lo", o_lo, 32'd10);
    chk("post_rst_hi", o_hi, 32'd0);
    chk("post_rst_stall", 32'(n), 32'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
